// File: rtl/dbus_mmio_responder.sv
// MMIO data-bus responder: stdout FIFO, test status, exit code, cycle counter.
// Define DBUS_RANDOM_STALL_EN to add LFSR-driven random grant stalls.
module dbus_mmio_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        stdout_valid_o,
   output logic [7:0]  stdout_data_o,
   input  logic        stdout_ready_i,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0]  wptr, rptr, count;
   logic [7:0]   mem [FIFO_DEPTH];
   logic [31:0]  cycle;
   logic [31:0]  rd_mux;
   logic [2:0]   off;
   logic         hit, fifo_full, stall, rnd_stall;
   logic         wr_stdout, wr_status, wr_exit, wr_cycle;
   logic         push, pop;
   logic         unused_ok;

   assign unused_ok = ^{data_be_i, data_addr_i[1:0]};

   assign hit = data_addr_i[31:5] == BASE_ADDR[31:5];
   assign off = data_addr_i[4:2];

   assign wr_stdout = data_req_i && data_we_i && hit && off == 3'd0;
   assign wr_status = data_gnt_o && data_we_i && hit && off == 3'd1;
   assign wr_exit   = data_gnt_o && data_we_i && hit && off == 3'd2;
   assign wr_cycle  = data_gnt_o && data_we_i && hit && off == 3'd3;

   assign count     = wptr - rptr;
   assign fifo_full = count == (AW + 1)'(FIFO_DEPTH);

   assign stall      = (wr_stdout && fifo_full) || rnd_stall;
   assign data_gnt_o = data_req_i && !stall;

`ifdef DBUS_RANDOM_STALL_EN
   logic [15:0] lfsr;
   logic [1:0]  stall_cnt;

   // Cap consecutive random stalls at 3 so a request is never starved.
   assign rnd_stall = data_req_i && lfsr[1:0] == 2'b00 && stall_cnt != 2'd3;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr      <= 16'hACE1;
         stall_cnt <= 2'd0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (!data_req_i || data_gnt_o)
            stall_cnt <= 2'd0;
         else if (stall_cnt != 2'd3)
            stall_cnt <= stall_cnt + 2'd1;
      end
   end
`else
   assign rnd_stall = 1'b0;
`endif

   assign push = data_gnt_o && wr_stdout;
   assign pop  = stdout_valid_o && stdout_ready_i;

   assign stdout_valid_o = count != '0;
   assign stdout_data_o  = stdout_valid_o ? mem[rptr[AW-1:0]] : 8'h00;

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wptr[AW-1:0]] <= data_wdata_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
      end
   end

   always_comb begin
      rd_mux = 32'h0;
      if (!hit)
         rd_mux = 32'hDEAD_BEEF;
      else if (!data_we_i) begin
         case (off)
            3'd0:    rd_mux = 32'(count);
            3'd1:    rd_mux = {30'b0, tests_failed_o, tests_passed_o};
            3'd2:    rd_mux = exit_value_o;
            3'd3:    rd_mux = cycle;
            default: rd_mux = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_rvalid_o  <= 1'b0;
         data_rdata_o   <= 32'h0;
         data_err_o     <= 1'b0;
         tests_passed_o <= 1'b0;
         tests_failed_o <= 1'b0;
         exit_valid_o   <= 1'b0;
         exit_value_o   <= 32'h0;
         cycle          <= 32'h0;
      end else begin
         data_rvalid_o <= data_gnt_o;
         data_rdata_o  <= data_gnt_o ? rd_mux : 32'h0;
         data_err_o    <= data_gnt_o && !hit;
         exit_valid_o  <= wr_exit;
         cycle         <= wr_cycle ? 32'h0 : cycle + 32'd1;
         if (wr_exit)
            exit_value_o <= data_wdata_i;
         if (wr_status && data_wdata_i == PASS_MAGIC)
            tests_passed_o <= 1'b1;
         if (wr_status && data_wdata_i == 32'd1)
            tests_failed_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dbus_mmio_responder.sv
// Scoreboard bench for dbus_mmio_responder.
// Driver queues expected responses; monitors check rvalid and stdout.
module tb_dbus_mmio_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk, rst_n;
   logic        req, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic        so_valid, so_ready;
   logic [7:0]  so_data;
   logic        passed, failed, ex_valid;
   logic [31:0] ex_value;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        sb [$];
   logic [7:0]  cq [$];
   int          n_chk, n_fail, n_drained;
   logic [31:0] ref_cyc;
   logic        cyc_clr;
   logic        gnt_q;

   dbus_mmio_responder dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .data_req_i     (req),
      .data_we_i      (we),
      .data_be_i      (be),
      .data_addr_i    (addr),
      .data_wdata_i   (wdata),
      .data_gnt_o     (gnt),
      .data_rvalid_o  (rvalid),
      .data_rdata_o   (rdata),
      .data_err_o     (err),
      .stdout_valid_o (so_valid),
      .stdout_data_o  (so_data),
      .stdout_ready_i (so_ready),
      .tests_passed_o (passed),
      .tests_failed_o (failed),
      .exit_valid_o   (ex_valid),
      .exit_value_o   (ex_value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference cycle counter; cleared by a granted CYCLE write.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ref_cyc <= 32'h0;
      else if (cyc_clr)
         ref_cyc <= 32'h0;
      else
         ref_cyc <= ref_cyc + 32'd1;
   end

   initial begin
      gnt_q = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rvalid || gnt_q)
               chk("rvalid_after_gnt", {31'b0, rvalid}, {31'b0, gnt_q});
            if (rvalid) begin
               if (sb.size() == 0)
                  chk("rsp_unexpected", 32'd1, 32'd0);
               else begin
                  rsp_t e;
                  e = sb.pop_front();
                  chk("rdata", rdata, e.rdata);
                  chk("err", {31'b0, err}, {31'b0, e.err});
               end
            end
            gnt_q = gnt;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && so_valid && so_ready) begin
            n_drained++;
            if (cq.size() == 0)
               chk("stdout_unexpected", 32'd1, 32'd0);
            else
               chk("stdout_byte", {24'b0, so_data}, {24'b0, cq.pop_front()});
         end
      end
   end

   // Call just after a posedge; returns just after the grant edge.
   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd,
                       input logic eerr, input logic is_cyc,
                       input int max_wait, output int waited);
      rsp_t r;
      req = 1'b1; we = w; addr = a; wdata = d;
      waited = 0;
      forever begin
         @(negedge clk);
         if (gnt) begin
            r.rdata = is_cyc ? ref_cyc : erd;
            r.err = eerr;
            sb.push_back(r);
            if (w && a == BASE)
               cq.push_back(d[7:0]);
            if (w && a == BASE + 32'hC)
               cyc_clr = 1'b1;
            break;
         end
         if (waited >= max_wait) begin
            chk("gnt_timeout", 32'(waited), 32'(max_wait));
            break;
         end
         waited++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req = 1'b0; cyc_clr = 1'b0;
   endtask

   int w;

   initial begin
      n_chk = 0; n_fail = 0; n_drained = 0;
      cyc_clr = 1'b0;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'hF;
      addr = 32'h0; wdata = 32'h0; so_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {26'b0, gnt, rvalid, err, so_valid, passed, failed},
          32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_exit", {31'b0, ex_valid} | ex_value, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      xfer(0, BASE + 32'hC, 0, 0, 0, 1, 0, w);
      chk("cyc_rd1_wait", 32'(w), 0);
      repeat (9) @(posedge clk);
      #1;
      xfer(0, BASE + 32'hC, 0, 0, 0, 1, 0, w);

      xfer(1, BASE + 32'h4, 32'd123456789, 0, 0, 0, 0, w);
      @(negedge clk);
      chk("passed_set", {30'b0, failed, passed}, 32'h1);
      @(posedge clk); #1;
      xfer(0, BASE + 32'h4, 0, 32'h1, 0, 0, 0, w);
      xfer(1, BASE + 32'h4, 32'd7, 0, 0, 0, 0, w);
      xfer(1, BASE + 32'h4, 32'd1, 0, 0, 0, 0, w);
      xfer(0, BASE + 32'h4, 0, 32'h3, 0, 0, 0, w);

      xfer(1, BASE + 32'h8, 32'h2A, 0, 0, 0, 0, w);
      @(negedge clk);
      chk("exit_pulse", {31'b0, ex_valid}, 32'h1);
      chk("exit_value", ex_value, 32'h2A);
      @(negedge clk);
      chk("exit_pulse_end", {31'b0, ex_valid}, 32'h0);
      chk("exit_value_hold", ex_value, 32'h2A);
      @(posedge clk); #1;
      xfer(0, BASE + 32'h8, 0, 32'h2A, 0, 0, 0, w);

      xfer(1, BASE + 32'hC, 32'h55, 0, 0, 0, 0, w);
      repeat (4) @(posedge clk);
      #1;
      xfer(0, BASE + 32'hC, 0, 0, 0, 1, 0, w);

      for (int i = 0; i < 8; i++) begin
         xfer(1, BASE, 32'(8'h41 + i), 0, 0, 0, 0, w);
         chk("fifo_fill_wait", 32'(w), 0);
      end
      xfer(0, BASE, 0, 32'd8, 0, 0, 0, w);
      fork
         xfer(1, BASE, 32'h49, 0, 0, 0, 20, w);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("full_gnt_low", {31'b0, gnt}, 32'h0);
            end
            @(posedge clk); #1;
            so_ready = 1'b1;
         end
      join
      chk("ninth_wait", 32'(w), 32'd4);
      for (int i = 0; i < 40 && so_valid; i++)
         @(posedge clk);
      #1;
      chk("drain_count", 32'(n_drained), 32'd9);

      xfer(0, 32'h2000_0000, 0, 32'hDEAD_BEEF, 1, 0, 0, w);
      chk("miss_wait", 32'(w), 0);
      xfer(1, BASE + 32'h14, 32'hFFFF_FFFF, 0, 0, 0, 0, w);
      xfer(0, BASE + 32'h10, 0, 32'h0, 0, 0, 0, w);
      xfer(0, BASE + 32'h4, 0, 32'h3, 0, 0, 0, w);
      xfer(0, BASE + 32'h8, 0, 32'h2A, 0, 0, 0, w);

      for (int i = 0; i < 1000; i++) begin
         int sel;
         int mw;
`ifdef DBUS_RANDOM_STALL_EN
         mw = 3;
`else
         mw = 0;
`endif
         sel = $urandom_range(0, 4);
         case (sel)
            0: xfer(0, BASE + 32'h4, 0, 32'h3, 0, 0, mw, w);
            1: xfer(0, BASE + 32'h18, 0, 32'h0, 0, 0, mw, w);
            2: xfer(1, BASE + 32'h1C, $urandom, 32'h0, 0, 0, mw, w);
            3: xfer(0, 32'h0000_0100, 0, 32'hDEAD_BEEF, 1, 0, mw, w);
            default: xfer(0, BASE + 32'h8, 0, 32'h2A, 0, 0, mw, w);
         endcase
         if (w > mw)
            chk("stall_gap", 32'(w), 32'(mw));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("sticky_flags", {30'b0, failed, passed}, 32'h3);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dbus_mmio_responder.md
Name: dbus_mmio_responder

Overview:
- Data-bus responder for the RI5CY testbench wrapper; it is the slave end of the core's data req/gnt/rvalid interface.
- Decodes a small MMIO window and produces the bench termination signals: tests_passed, tests_failed, exit_valid and exit_value.
- Buffers stdout characters in a FIFO and exposes a free-running cycle counter.
- The wrapper instantiates it beside the RAM. Its pass/fail/exit outputs feed the top-level checker.

Parameters:
- BASE_ADDR, 32'h1000_0000: base of the 32-byte MMIO window; bits [4:0] are the offset.
- FIFO_DEPTH, 8: stdout FIFO entries; must be a power of 2 and at least 2.
- PASS_MAGIC, 32'd123456789: TEST_STATUS write value that signals pass.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  1  request; held until granted.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables; ignored except STDOUT uses byte 0.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  grant.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  error, qualified by rvalid.
- stdout_valid_o  out  1  FIFO non-empty.
- stdout_data_o  out  8  FIFO head byte.
- stdout_ready_i  in  1  consumer pops when valid & ready.
- tests_passed_o  out  1  sticky pass.
- tests_failed_o  out  1  sticky fail.
- exit_valid_o  out  1  one-cycle exit pulse.
- exit_value_o  out  32  exit code.

Behaviour:
- Reset: async on rst_ni low. All outputs are 0, the FIFO is empty, CYCLE=0 and the LFSR is at its seed. Reset mid-transaction drops any pending rvalid.
- Hit: data_req_i && data_addr_i[31:5]==BASE_ADDR[31:5].
- Miss: any request outside the window. It is still granted and answered, with err=1 and rdata=32'hDEAD_BEEF. The block is the sole slave in the bench.
- Handshake:
  - gnt_o is combinational: req && !stall.
  - stall = (STDOUT write && FIFO full) || random stall (see Optional Feature).
  - With FIFO full, gnt stays low even if a pop happens in the same cycle; the grant comes the cycle after.
  - Side effects take place on the grant cycle.
  - rvalid_o is registered and asserts exactly 1 cycle after each grant, for reads and writes alike.
  - rdata/err are registered alongside rvalid. Write responses carry rdata=0.
  - Back-to-back grants are allowed on consecutive cycles; each gets its own rvalid.
- Register map (offset, access):
  - 0x00 STDOUT:
    - W: push wdata[7:0].
    - R: {count[31:0]}, the FIFO fill level.
  - 0x04 TEST_STATUS:
    - W PASS_MAGIC: tests_passed_o=1.
    - W 1: tests_failed_o=1.
    - Other values are ignored.
    - Both flags stay sticky until reset.
    - R: {30'b0, failed, passed}.
  - 0x08 EXIT:
    - W: exit_value_o<=wdata; exit_valid_o=1 for exactly the cycle after the grant.
    - exit_value_o holds its value after the pulse.
    - R: exit_value_o.
  - 0x0C CYCLE:
    - R: 32-bit counter, +1 per clock from reset, wraps 0xFFFF_FFFF to 0.
    - W: counter loads 0 on the next edge. Write wins over increment.
  - 0x10-0x1C: reserved. Reads return 0, writes are ignored, err=0.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers.
  - Push and pop in the same cycle (not full) leaves count unchanged.
  - A pop when empty is ignored.
  - stdout_data_o is the head entry and is undefined when empty.
- A granted STDOUT write never overflows the FIFO, because the stall rule guarantees space.

Optional Feature:
- Macro DBUS_RANDOM_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every cycle.
  - A request is stalled when lfsr[1:0]==2'b00.
  - At most 3 consecutive stall cycles per request. The 4th cycle forces a grant, subject only to FIFO full.
- Undefined: no LFSR logic; stalls come only from the FIFO-full condition.

Test Plan:
- Reset release, then a read of 0x1000_000C on two reads 10 cycles apart -> rvalid 1 cycle after each gnt; second value minus first = 10; err=0.
- Write 0x1000_0004 = 123456789 -> tests_passed_o rises the cycle after grant and stays 1; a read returns 0x1; a later write of 1 also sets tests_failed_o (read returns 0x3).
- Write 0x1000_0008 = 0x2A -> exit_valid_o high for exactly 1 cycle, exit_value_o=0x2A and held afterwards.
- stdout_ready_i=0, then 9 writes to 0x1000_0000 of 'A'..'I' -> first 8 granted; the 9th waits with gnt=0; a STDOUT read, once reachable, shows count=8; raise ready -> 'A' popped, 9th granted the next cycle, drain order is A..I.
- Read of 0x2000_0000 -> gnt same cycle, rvalid next cycle, err=1, rdata=0xDEADBEEF; write to offset 0x14 -> err=0, no state change.
- With DBUS_RANDOM_STALL_EN, 1000 random requests -> no gnt-to-gnt gap above 3 cycles (FIFO not full), and exactly one rvalid per gnt.
